// File: rtl/wb_stream_reader_ctrl.sv
// Stream-to-Wishbone writer: buffers an incoming stream in a FWFT FIFO and writes it to memory
// as incrementing bursts, one transfer per enable rising edge.
module wb_stream_reader_ctrl #(
  parameter int unsigned WB_DW         = 32,
  parameter int unsigned WB_AW         = 32,
  parameter int unsigned FIFO_AW       = 4,
  parameter int unsigned MAX_BURST_LEN = 2**FIFO_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Wishbone master
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic                 wbm_rty_i,
  // Stream sink
  input  logic [WB_DW-1:0]     stream_s_data_i,
  input  logic                 stream_s_valid_i,
  output logic                 stream_s_ready_o,
  // Control / status
  input  logic                 enable,
  input  logic [WB_AW-1:0]     start_adr,
  input  logic [WB_AW-1:0]     buf_size,
  input  logic [WB_AW-1:0]     burst_size,
  output logic                 busy,
  output logic [WB_AW-1:0]     tx_cnt,
  output logic                 irq,
  output logic                 err
);

  localparam int unsigned Depth = 2**FIFO_AW;
  localparam int unsigned Bytes = WB_DW / 8;
  localparam logic [WB_AW-1:0] MaxBurst = WB_AW'(MAX_BURST_LEN);

  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

  state_e             state_q;
  logic               enable_q;
  logic [WB_AW-1:0]   start_adr_q;
  logic [WB_AW-1:0]   buf_size_q;
  logic [WB_AW-1:0]   burst_size_q;
  logic [WB_AW-1:0]   burst_rem_q;

  logic [WB_DW-1:0]   mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;

  logic               in_burst;
  logic               push;
  logic               pop;
  logic               final_beat;
  logic [WB_AW-1:0]   fifo_level;
  logic [WB_AW-1:0]   remaining;
  logic [WB_AW-1:0]   burst_len;
  logic [WB_AW-1:0]   tx_next;

  logic               unused_inputs;
  assign unused_inputs = ^{wbm_dat_i, wbm_rty_i};

  // ---------------------------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------------------------
  assign in_burst         = (state_q == StBurst);
  assign stream_s_ready_o = (count_q < (FIFO_AW + 1)'(Depth));
  assign push             = stream_s_valid_i && stream_s_ready_o;
  // An errored beat is not consumed, so its word stays at the head.
  assign pop              = in_burst && wbm_ack_i && !wbm_err_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= stream_s_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Burst length and bus outputs
  // ---------------------------------------------------------------------------------------------
  assign fifo_level = WB_AW'(count_q);
  assign tx_next    = tx_cnt + WB_AW'(1);
  assign final_beat = (burst_rem_q == WB_AW'(1));

  always_comb begin
    remaining = buf_size_q - tx_cnt;
    burst_len = (burst_size_q == '0) ? WB_AW'(1) : burst_size_q;
    if (burst_len > MaxBurst) begin
      burst_len = MaxBurst;
    end
    if (burst_len > remaining) begin
      burst_len = remaining;
    end
  end

  assign wbm_cyc_o = in_burst;
  assign wbm_stb_o = in_burst;
  assign wbm_we_o  = in_burst;
  assign wbm_sel_o = in_burst ? '1 : '0;
  assign wbm_bte_o = 2'b00;
  assign wbm_adr_o = in_burst ? (start_adr_q + tx_cnt * WB_AW'(Bytes)) : '0;
  assign wbm_dat_o = in_burst ? mem[rd_ptr_q] : '0;
  assign wbm_cti_o = !in_burst ? 3'b000 : (final_beat ? 3'b111 : 3'b010);

  // ---------------------------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      enable_q     <= 1'b0;
      start_adr_q  <= '0;
      buf_size_q   <= '0;
      burst_size_q <= '0;
      burst_rem_q  <= '0;
      tx_cnt       <= '0;
      busy         <= 1'b0;
      irq          <= 1'b0;
      err          <= 1'b0;
    end else begin
      enable_q <= enable;
      irq      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable && !enable_q) begin
            start_adr_q  <= start_adr;
            buf_size_q   <= buf_size;
            burst_size_q <= burst_size;
            tx_cnt       <= '0;
            err          <= 1'b0;
            busy         <= 1'b1;
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (buf_size_q == '0) begin
            busy    <= 1'b0;
            irq     <= 1'b1;
            state_q <= StIdle;
          end else if (fifo_level >= burst_len) begin
            burst_rem_q <= burst_len;
            state_q     <= StBurst;
          end
        end
        StBurst: begin
          if (wbm_err_i) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (wbm_ack_i) begin
            tx_cnt      <= tx_next;
            burst_rem_q <= burst_rem_q - WB_AW'(1);
            if (final_beat) begin
              if (tx_next == buf_size_q) begin
                busy    <= 1'b0;
                irq     <= 1'b1;
                state_q <= StIdle;
              end else begin
                state_q <= StWait;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// Bench for wb_stream_reader_ctrl: a transfer-level model checked every cycle plus directed
// scenarios with literal expectations.
module tb_wb_stream_reader_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;
  logic [31:0] stream_s_data_i = '0;
  logic        stream_s_valid_i = 1'b0;
  logic        stream_s_ready_o;
  logic        enable = 1'b0;
  logic [31:0] start_adr = '0;
  logic [31:0] buf_size = '0;
  logic [31:0] burst_size = '0;
  logic        busy;
  logic [31:0] tx_cnt;
  logic        irq;
  logic        err;

  // Bus responder controls
  logic        ack_en = 1'b0;
  logic        rty_mode = 1'b0;
  logic        rty_phase = 1'b0;
  int          beats_done = 0;
  int          err_at = -1;

  assign wbm_err_i = wbm_cyc_o && (beats_done == err_at);
  assign wbm_ack_i = wbm_cyc_o && ack_en && !rty_phase && (beats_done != err_at);
  assign wbm_rty_i = wbm_cyc_o && ack_en && rty_phase && (beats_done != err_at);

  wb_stream_reader_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wbm_adr_o        (wbm_adr_o),
    .wbm_dat_o        (wbm_dat_o),
    .wbm_sel_o        (wbm_sel_o),
    .wbm_we_o         (wbm_we_o),
    .wbm_cyc_o        (wbm_cyc_o),
    .wbm_stb_o        (wbm_stb_o),
    .wbm_cti_o        (wbm_cti_o),
    .wbm_bte_o        (wbm_bte_o),
    .wbm_dat_i        (wbm_dat_i),
    .wbm_ack_i        (wbm_ack_i),
    .wbm_err_i        (wbm_err_i),
    .wbm_rty_i        (wbm_rty_i),
    .stream_s_data_i  (stream_s_data_i),
    .stream_s_valid_i (stream_s_valid_i),
    .stream_s_ready_o (stream_s_ready_o),
    .enable           (enable),
    .start_adr        (start_adr),
    .buf_size         (buf_size),
    .burst_size       (burst_size),
    .busy             (busy),
    .tx_cnt           (tx_cnt),
    .irq              (irq),
    .err              (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  // Transfer-level model
  logic [31:0] m_q[$];
  logic        m_busy = 1'b0;
  logic        m_irq = 1'b0;
  logic        m_err = 1'b0;
  logic        m_en_prev = 1'b0;
  logic        m_in_burst = 1'b0;
  logic [31:0] m_start = '0;
  logic [31:0] m_buf = '0;
  logic [31:0] m_bsz = '0;
  logic [31:0] m_tx = '0;
  int          m_beat = 0;
  int          m_blen = 0;
  logic        m_pushed = 1'b0;
  logic        ack_taken = 1'b0;
  int          irq_cnt = 0;
  logic [31:0] log_adr[$];
  logic [2:0]  log_cti[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tfail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: bound expired, got timeout required completion at %0t", name, $time);
  endtask

  function automatic int calc_blen();
    longint b;
    longint rem;
    b = (m_bsz == 0) ? 1 : longint'(m_bsz);
    if (b > DEPTH) b = DEPTH;
    rem = longint'(m_buf) - longint'(m_tx);
    if (b > rem) b = rem;
    return int'(b);
  endfunction

  // Runs at the falling edge: checks outputs, then advances the model to the next rising edge.
  task automatic model_step();
    logic was_busy;
    logic mr;
    ack_taken = 1'b0;
    m_pushed  = 1'b0;
    if (irq) irq_cnt++;
    if (!rst_n) begin
      chk("rst_cyc", wbm_cyc_o, 0);
      chk("rst_stb", wbm_stb_o, 0);
      chk("rst_ready", stream_s_ready_o, 1);
      chk("rst_busy", busy, 0);
      chk("rst_tx", tx_cnt, 0);
      chk("rst_irq", irq, 0);
      chk("rst_err", err, 0);
      chk("rst_adr", wbm_adr_o, 0);
      m_q.delete();
      m_busy = 0; m_irq = 0; m_err = 0; m_tx = '0; m_beat = 0;
      m_in_burst = 0; m_en_prev = 0;
      return;
    end
    mr = (m_q.size() < DEPTH);
    chk("ready", stream_s_ready_o, mr);
    chk("busy", busy, m_busy);
    chk("irq", irq, m_irq);
    chk("err", err, m_err);
    chk("tx_cnt", tx_cnt, m_tx);
    if (wbm_cyc_o) begin
      if (!m_in_burst) begin
        m_blen = calc_blen();
        chk("burst_fill", m_q.size() >= m_blen, 1);
        chk("burst_busy", m_busy && (m_buf != 0), 1);
        m_in_burst = 1;
      end
      chk("stb", wbm_stb_o, 1);
      chk("we", wbm_we_o, 1);
      chk("sel", wbm_sel_o, 4'hF);
      chk("bte", wbm_bte_o, 0);
      chk("adr", wbm_adr_o, m_start + m_tx * 4);
      chk("cti", wbm_cti_o, (m_beat == m_blen - 1) ? 3'b111 : 3'b010);
      if (m_q.size() != 0) chk("dat", wbm_dat_o, m_q[0]);
      else tfail("dat_underflow");
    end else begin
      chk("idle_stb", wbm_stb_o, 0);
      chk("idle_we", wbm_we_o, 0);
      chk("idle_cti", wbm_cti_o, 0);
      chk("burst_drop", m_in_burst, 0);
      m_in_burst = 0;
    end

    was_busy = m_busy;
    m_irq = 0;
    if (m_busy && m_buf == 0) begin
      m_busy = 0; m_irq = 1;
    end else if (wbm_cyc_o && wbm_err_i) begin
      m_busy = 0; m_err = 1; m_in_burst = 0; m_beat = 0;
    end else if (wbm_cyc_o && wbm_ack_i) begin
      if (m_q.size() != 0) void'(m_q.pop_front());
      log_adr.push_back(wbm_adr_o);
      log_cti.push_back(wbm_cti_o);
      m_tx++; m_beat++; ack_taken = 1;
      if (m_beat == m_blen) begin
        m_beat = 0; m_in_burst = 0;
        if (m_tx == m_buf) begin m_busy = 0; m_irq = 1; end
      end
    end
    if (!was_busy && enable && !m_en_prev) begin
      m_start = start_adr; m_buf = buf_size; m_bsz = burst_size;
      m_tx = '0; m_err = 0; m_busy = 1; m_beat = 0;
    end
    if (stream_s_valid_i && mr) begin
      m_q.push_back(stream_s_data_i);
      m_pushed = 1;
    end
    m_en_prev = enable;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (ack_taken) beats_done++;
    rty_phase = rty_mode ? ~rty_phase : 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    int t = 0;
    stream_s_valid_i = 1'b1;
    stream_s_data_i  = w;
    do begin
      tick();
      t++;
    end while (!m_pushed && t < 200);
    if (!m_pushed) tfail("send_timeout");
    stream_s_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (m_busy && t < 500) begin
      tick();
      t++;
    end
    if (m_busy) tfail("idle_timeout");
    tick();
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    start_adr = a; buf_size = b; burst_size = s;
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  initial begin
    int base;
    int i0;
    int t;

    tick();
    tick();
    chk("reset_cyc", wbm_cyc_o, 0);
    chk("reset_ready", stream_s_ready_o, 1);
    chk("reset_busy", busy, 0);
    chk("reset_tx", tx_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Two 4-beat bursts, ack every cycle
    ack_en = 1'b1;
    base = log_adr.size(); i0 = irq_cnt;
    start_xfer(32'h1000, 8, 4);
    for (int i = 0; i < 8; i++) send(32'hA000_0000 + i);
    wait_idle();
    chk("t1_tx", tx_cnt, 8);
    chk("t1_irq", irq_cnt - i0, 1);
    chk("t1_beats", log_adr.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_adr", log_adr[base + i], 32'h1000 + 4 * i);
      chk("t1_cti", log_cti[base + i], (i % 4 == 3) ? 3'b111 : 3'b010);
    end

    // 4-beat then single-beat burst, with retries interleaved
    rty_mode = 1'b1;
    base = log_adr.size(); i0 = irq_cnt;
    start_xfer(32'h1000, 5, 4);
    for (int i = 0; i < 5; i++) send(32'hB000_0000 + i);
    wait_idle();
    rty_mode = 1'b0;
    chk("t2_tx", tx_cnt, 5);
    chk("t2_beats", log_adr.size() - base, 5);
    chk("t2_cti3", log_cti[base + 3], 3'b111);
    chk("t2_adr4", log_adr[base + 4], 32'h1010);
    chk("t2_cti4", log_cti[base + 4], 3'b111);
    chk("t2_irq", irq_cnt - i0, 1);

    // Fill the FIFO with ack held low; mid-transfer enable edge must be ignored
    ack_en = 1'b0;
    base = log_adr.size();
    start_xfer(32'h4000, 20, 32);
    for (int i = 0; i < 16; i++) send(32'hC000_0000 + i);
    stream_s_valid_i = 1'b1;
    stream_s_data_i  = 32'hC000_0010;
    tick();
    chk("t3_full0", stream_s_ready_o, 0);
    start_xfer(32'h9000, 1, 1);
    chk("t3_full1", stream_s_ready_o, 0);
    tick();
    chk("t3_full2", stream_s_ready_o, 0);
    ack_en = 1'b1;
    for (int i = 16; i < 20; i++) send(32'hC000_0000 + i);
    wait_idle();
    chk("t3_tx", tx_cnt, 20);
    chk("t3_beats", log_adr.size() - base, 20);
    chk("t3_cti0", log_cti[base], 3'b010);
    chk("t3_cti15", log_cti[base + 15], 3'b111);
    chk("t3_adr16", log_adr[base + 16], 32'h4040);

    // Bus error on the second beat
    i0 = irq_cnt;
    err_at = beats_done + 1;
    start_xfer(32'h2000, 4, 4);
    for (int i = 0; i < 4; i++) send(32'hD000_0000 + i);
    wait_idle();
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_cyc", wbm_cyc_o, 0);
    chk("t4_tx", tx_cnt, 1);
    chk("t4_noirq", irq_cnt - i0, 0);
    err_at = -1;
    start_xfer(32'h3000, 3, 2);
    chk("t4_errclr", err, 0);
    wait_idle();
    chk("t4_tx2", tx_cnt, 3);
    chk("t4_irq2", irq_cnt - i0, 1);

    // Zero-length buffer
    start_xfer(32'h6000, 0, 4);
    chk("t5_busy", busy, 1);
    tick();
    chk("t5_irq", irq, 1);
    chk("t5_idle", busy, 0);
    tick();
    chk("t5_irq_off", irq, 0);

    // Reset in the middle of a burst
    ack_en = 1'b0;
    start_xfer(32'h5000, 8, 4);
    for (int i = 0; i < 4; i++) send(32'hF000_0000 + i);
    t = 0;
    while (!wbm_cyc_o && t < 50) begin
      tick();
      t++;
    end
    if (!wbm_cyc_o) tfail("t6_cyc_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_cyc", wbm_cyc_o, 0);
    chk("t6_ready", stream_s_ready_o, 1);
    chk("t6_tx", tx_cnt, 0);
    chk("t6_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    ack_en = 1'b1;
    base = log_adr.size();
    start_xfer(32'h7000, 2, 1);
    send(32'hE000_0000);
    send(32'hE000_0001);
    wait_idle();
    chk("t6_beats", log_adr.size() - base, 2);
    chk("t6_adr1", log_adr[base + 1], 32'h7004);
    chk("t6_cti1", log_cti[base + 1], 3'b111);
    chk("t6_tx2", tx_cnt, 2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
